// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
//
// Byte buffer and launch sequencer feeding the debug unit's UART transmitter.
// Bytes are pushed at full clock rate. One byte at a time is popped and handed
// to the transmitter with a single-cycle start pulse. The next byte is not
// launched until the transmitter's done flag has gone low (busy) and come back
// high (idle).
//
// Optional build macro: UART_TX_FIFO_OVF_EN
//   When defined, adds a sticky o_overflow flag that records any push attempted
//   while full, and an i_clr_ovf input that clears it.
//
// Parameters:
//   NBITS      data width per entry
//   ADDR_BITS  pointer width; depth is 2**ADDR_BITS entries
//
// Ports:
//   clk         clock
//   rst         asynchronous reset, active low
//   i_wr_en     push request
//   i_wr_data   byte to push
//   o_full      registered, occupancy == depth
//   o_empty     registered, occupancy == 0
//   o_count     registered occupancy, 0..depth
//   i_tx_done   transmitter idle flag (1 = idle)
//   o_tx_start  registered one-cycle launch pulse
//   o_tx_data   registered byte to transmitter, held until the next pop
//   o_overflow  sticky dropped-push flag   (UART_TX_FIFO_OVF_EN only)
//   i_clr_ovf   clears o_overflow          (UART_TX_FIFO_OVF_EN only)
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int NBITS     = 8,
    parameter int ADDR_BITS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [NBITS-1:0]     i_wr_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [ADDR_BITS:0]   o_count,
    input  logic                 i_tx_done,
    output logic                 o_tx_start,
    output logic [NBITS-1:0]     o_tx_data
`ifdef UART_TX_FIFO_OVF_EN
    ,
    output logic                 o_overflow,
    input  logic                 i_clr_ovf
`endif
);

    localparam int                   DEPTH    = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS:0]   FULL_CNT = {1'b1, {ADDR_BITS{1'b0}}};
    localparam logic [ADDR_BITS-1:0] PTR_ONE  = ADDR_BITS'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [NBITS-1:0]     mem_q [DEPTH];
    logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_BITS:0]   count_q, count_d;
    logic                 full_q, full_d;
    logic                 empty_q, empty_d;
    logic                 tx_start_q, tx_start_d;
    logic [NBITS-1:0]     tx_data_q, tx_data_d;
    logic                 push;
    logic                 pop;

    // Acceptance uses the registered full flag, so a pop in the same edge
    // does not make room for a push while full.
    assign push = i_wr_en & ~full_q;

    // Launch sequencer: the pop happens on the IDLE->LAUNCH decision so the
    // byte and the start pulse appear together in the LAUNCH cycle.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty_q && i_tx_done) begin
                    state_d = LAUNCH;
                    pop     = 1'b1;
                end
            end
            LAUNCH:    state_d = WAIT_BUSY;
            WAIT_BUSY: if (!i_tx_done) state_d = WAIT_DONE;
            WAIT_DONE: if (i_tx_done)  state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d   = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d   = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d    = count_q + (ADDR_BITS+1)'(push) - (ADDR_BITS+1)'(pop);
        full_d     = (count_d == FULL_CNT);
        empty_d    = (count_d == '0);
        tx_start_d = pop;
        tx_data_d  = pop ? mem_q[rd_ptr_q] : tx_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
        end
    end

    // Storage needs no reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_wr_data;
        end
    end

    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_count    = count_q;
    assign o_tx_start = tx_start_q;
    assign o_tx_data  = tx_data_q;

`ifdef UART_TX_FIFO_OVF_EN
    logic ovf_q, ovf_d;

    // Set has priority over clear when both happen in the same edge.
    always_comb begin
        ovf_d = (i_wr_en & full_q) | (ovf_q & ~i_clr_ovf);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_overflow = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
//
// Self-checking bench for uart_tx_fifo. A queue-based reference model predicts
// occupancy, flags, launch pulses and launched data every cycle; a simple
// transmitter model drives i_tx_done (drops two cycles after each start pulse,
// stays low for a configurable or random time). Directed scenarios add
// hand-computed literal expectations; a randomized phase follows.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_wr_en = 1'b0;
    logic [7:0] i_wr_data = 8'h00;
    logic       i_clr_ovf = 1'b0;
    logic       i_tx_done;
    logic       o_full, o_empty, o_tx_start;
    logic [4:0] o_count;
    logic [7:0] o_tx_data;
`ifdef UART_TX_FIFO_OVF_EN
    logic       o_overflow;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_tx_fifo #(.NBITS(8), .ADDR_BITS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (i_wr_en),
        .i_wr_data  (i_wr_data),
        .o_full     (o_full),
        .o_empty    (o_empty),
        .o_count    (o_count),
        .i_tx_done  (i_tx_done),
        .o_tx_start (o_tx_start),
        .o_tx_data  (o_tx_data)
`ifdef UART_TX_FIFO_OVF_EN
        ,
        .o_overflow (o_overflow),
        .i_clr_ovf  (i_clr_ovf)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- transmitter model ----------------
    bit         tx_idle    = 1'b1;
    bit         hold_busy  = 1'b0;
    int         drop_in    = 0;
    int         busy_left  = 0;
    int         busy_fixed = 0;
    logic [7:0] tx_log[$];

    assign i_tx_done = tx_idle & ~hold_busy;

    always @(negedge clk) begin
        if (rst && o_tx_start) begin
            tx_log.push_back(o_tx_data);
            drop_in = 2;
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst) begin
            tx_idle   = 1'b1;
            drop_in   = 0;
            busy_left = 0;
        end else if (drop_in > 0) begin
            drop_in--;
            if (drop_in == 0) begin
                tx_idle   = 1'b0;
                busy_left = (busy_fixed > 0) ? busy_fixed : int'($urandom_range(1, 12));
            end
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_idle = 1'b1;
        end
    end

    // ---------------- reference model ----------------
    // Queue of stored bytes; a transfer is "in flight" from the launch until
    // done has been seen low and then high again.
    logic [7:0] mq[$];
    logic [7:0] m_data     = 8'h00;
    bit         m_start    = 1'b0;
    bit         m_inflight = 1'b0;
    bit         m_saw_low  = 1'b0;
    bit         m_ovf      = 1'b0;
    bit         chk_en     = 1'b0;
    int         m_n;
    bit         m_pop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_data     = 8'h00;
            m_start    = 1'b0;
            m_inflight = 1'b0;
            m_saw_low  = 1'b0;
            m_ovf      = 1'b0;
        end else begin
            m_n   = mq.size();
            m_pop = 1'b0;
            if (m_start) begin
                m_start    = 1'b0;
                m_inflight = 1'b1;
                m_saw_low  = 1'b0;
            end else if (m_inflight) begin
                if (!m_saw_low) begin
                    if (!i_tx_done) m_saw_low = 1'b1;
                end else if (i_tx_done) begin
                    m_inflight = 1'b0;
                end
            end else if (m_n > 0 && i_tx_done) begin
                m_pop = 1'b1;
            end
            if (i_wr_en && m_n == DEPTH) m_ovf = 1'b1;
            else if (i_clr_ovf)          m_ovf = 1'b0;
            if (m_pop) begin
                m_data  = mq.pop_front();
                m_start = 1'b1;
            end
            if (i_wr_en && m_n < DEPTH) mq.push_back(i_wr_data);
        end
    end

    always @(negedge clk) begin
        if (rst && chk_en) begin
            check("count",    o_count,    mq.size());
            check("full",     o_full,     mq.size() == DEPTH);
            check("empty",    o_empty,    mq.size() == 0);
            check("tx_start", o_tx_start, m_start);
            check("tx_data",  o_tx_data,  m_data);
`ifdef UART_TX_FIFO_OVF_EN
            check("overflow", o_overflow, m_ovf);
`endif
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        i_wr_en   = 1'b1;
        i_wr_data = d;
        step();
        i_wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (mq.size() == 0 && !m_start && !m_inflight && tx_idle && drop_in == 0) return;
            step();
        end
        n_checks++;
        n_fail++;
        $display("FAIL drain_timeout: still busy after %0d cycles, queue %0d", budget, mq.size());
    endtask

    function automatic logic [7:0] log_at(input int i);
        if (i < tx_log.size()) return tx_log[i];
        return 8'hxx;
    endfunction

    task automatic pulse_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    logic [7:0] exp3 [16];
    bit         reached;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset state
        step();
        step();
        check("rst_count", o_count, 0);
        check("rst_empty", o_empty, 1);
        check("rst_full",  o_full, 0);
        check("rst_start", o_tx_start, 0);
        check("rst_data",  o_tx_data, 0);
`ifdef UART_TX_FIFO_OVF_EN
        check("rst_ovf",   o_overflow, 0);
`endif
        rst = 1'b1;
        chk_en = 1'b1;
        step();

        // 1: single byte, start two edges after the push edge
        push(8'hA5);
        check("t1_count_after_push", o_count, 1);
        check("t1_start_early", o_tx_start, 0);
        step();
        check("t1_start", o_tx_start, 1);
        check("t1_data",  o_tx_data, 8'hA5);
        check("t1_empty", o_empty, 1);
        step();
        check("t1_start_once", o_tx_start, 0);
        check("t1_data_hold",  o_tx_data, 8'hA5);
        wait_drain(200);

        // 2: three bytes, long transmitter busy time
        busy_fixed = 160;
        tx_log.delete();
        push(8'h11);
        push(8'h22);
        push(8'h33);
        wait_drain(2000);
        check("t2_n",  tx_log.size(), 3);
        check("t2_b0", log_at(0), 8'h11);
        check("t2_b1", log_at(1), 8'h22);
        check("t2_b2", log_at(2), 8'h33);
        busy_fixed = 0;

        // 3: fill with done held low, overflow attempt
        tx_log.delete();
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp3[i] = 8'($urandom_range(0, 254));
            push(exp3[i]);
        end
        check("t3_count16", o_count, 16);
        check("t3_full",    o_full, 1);
        push(8'hFF);
        check("t3_count_drop", o_count, 16);
`ifdef UART_TX_FIFO_OVF_EN
        check("t3_ovf_set", o_overflow, 1);
        step();
        check("t3_ovf_sticky", o_overflow, 1);
        i_clr_ovf = 1'b1;
        step();
        i_clr_ovf = 1'b0;
        check("t3_ovf_clr", o_overflow, 0);
        i_clr_ovf = 1'b1;
        push(8'hFF);
        i_clr_ovf = 1'b0;
        check("t3_ovf_set_wins", o_overflow, 1);
        i_clr_ovf = 1'b1;
        step();
        i_clr_ovf = 1'b0;
`else
        push(8'hFF);
`endif
        check("t3_count_drop2", o_count, 16);
        hold_busy = 1'b0;
        wait_drain(3000);
        check("t3_n", tx_log.size(), 16);
        for (int i = 0; i < 16; i++) check("t3_order", log_at(i), exp3[i]);

        // 5: push in the same edge as the launch pop, count 3
        tx_log.delete();
        hold_busy = 1'b1;
        push(8'h41);
        push(8'h42);
        push(8'h43);
        check("t5_count3_pre", o_count, 3);
        hold_busy = 1'b0;
        push(8'h44);
        check("t5_count3", o_count, 3);
        check("t5_start",  o_tx_start, 1);
        check("t5_data",   o_tx_data, 8'h41);
        wait_drain(1000);
        check("t5_n",  tx_log.size(), 4);
        check("t5_b0", log_at(0), 8'h41);
        check("t5_b1", log_at(1), 8'h42);
        check("t5_b2", log_at(2), 8'h43);
        check("t5_b3", log_at(3), 8'h44);

        // Randomized traffic
        for (int c = 0; c < 1500; c++) begin
            i_wr_en   = ($urandom_range(0, 99) < 45);
            i_wr_data = 8'($urandom);
            i_clr_ovf = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 99) < 3) hold_busy = ~hold_busy;
            step();
        end
        i_wr_en   = 1'b0;
        i_clr_ovf = 1'b0;
        hold_busy = 1'b0;
        wait_drain(5000);

        // 4: pointer wrap from reset
        pulse_reset();
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) push(8'($urandom_range(0, 255)));
        hold_busy = 1'b0;
        wait_drain(3000);
        tx_log.delete();
        push(8'h5A);
        check("t4_count1", o_count, 1);
        step();
        check("t4_count0", o_count, 0);
        check("t4_start",  o_tx_start, 1);
        check("t4_data",   o_tx_data, 8'h5A);
        wait_drain(200);
        check("t4_log", log_at(0), 8'h5A);

        // 6: reset during WAIT_DONE with five bytes queued
        busy_fixed = 40;
        for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            if (m_inflight && m_saw_low && mq.size() == 5) reached = 1'b1;
            else step();
        end
        check("t6_reached_wait_done", reached, 1);
        check("t6_data_before", o_tx_data, 8'h60);
        #2;
        rst = 1'b0;
        #1;
        check("t6_start", o_tx_start, 0);
        check("t6_count", o_count, 0);
        check("t6_empty", o_empty, 1);
        check("t6_full",  o_full, 0);
        check("t6_data",  o_tx_data, 0);
        step();
        step();
        rst = 1'b1;
        busy_fixed = 0;
        tx_log.delete();
        for (int i = 0; i < 30; i++) step();
        check("t6_no_launch", tx_log.size(), 0);
        check("t6_count_idle", o_count, 0);
        push(8'h3C);
        wait_drain(200);
        check("t6_new_n",    tx_log.size(), 1);
        check("t6_new_byte", log_at(0), 8'h3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and launch sequencer directly upstream of the UART transmitter in the debug unit.
- Debug-unit logic pushes bytes at full clock rate.
- This block pops one byte at a time and presents it to the transmitter with a single-cycle start pulse.
- It waits for the transmitter's done flag to complete a full busy/idle cycle before launching the next byte.
- It decouples burst writes from the 16x-oversampled serial rate.

Parameters:
NBITS, 8, data width per entry; matches transmitter data width.
ADDR_BITS, 4, pointer width; DEPTH = 2**ADDR_BITS entries (16).

Ports:
clk  input  1  clock (already decided).
rst  input  1  asynchronous, active-low reset (already decided).
i_wr_en  input  1  push request, sampled on rising clk.
i_wr_data  input  NBITS  byte to push.
o_full  output  1  registered; count == DEPTH.
o_empty  output  1  registered; count == 0.
o_count  output  ADDR_BITS+1  registered occupancy, 0..DEPTH.
i_tx_done  input  1  transmitter done/idle flag (1 = idle).
o_tx_start  output  1  registered one-cycle launch pulse to transmitter.
o_tx_data  output  NBITS  registered byte to transmitter; stable from start pulse until next pop.
o_overflow  output  1  only with UART_TX_FIFO_OVF_EN.
i_clr_ovf  input  1  only with UART_TX_FIFO_OVF_EN.

Behaviour:
Reset (async, rst=0): wr_ptr=rd_ptr=0; o_count=0; o_empty=1; o_full=0; o_tx_start=0; o_tx_data=0; state=IDLE; o_overflow=0. Storage contents are don't-care.

Write side:
- Push accepted iff i_wr_en=1 and registered o_full=0: mem[wr_ptr] <= i_wr_data, wr_ptr+1 (wraps modulo DEPTH).
- Push while full is dropped silently; pointers and count are unchanged.

Pop:
- Occurs only on the IDLE->LAUNCH transition: o_tx_data <= mem[rd_ptr], rd_ptr+1 (wraps).

Count:
- count + push_accepted - pop, in the same edge.
- Simultaneous accepted push and pop leaves count unchanged.
- o_full and o_empty are derived from the next count and registered with it.

Launch FSM (2-bit):
- IDLE: if o_empty=0 and i_tx_done=1 -> LAUNCH (pop). Otherwise stay.
- LAUNCH: o_tx_start=1 for exactly this one cycle -> WAIT_BUSY.
- WAIT_BUSY: stay until i_tx_done=0, then -> WAIT_DONE. The transmitter drops done two cycles after the start pulse; no timeout.
- WAIT_DONE: stay until i_tx_done=1, then -> IDLE.

Latency and back-to-back:
- Push sampled at edge N into an empty FIFO with the transmitter idle: o_tx_start is high in the cycle after edge N+1, with o_tx_data = that byte in the same cycle.
- Next launch at the earliest is 2 cycles after i_tx_done returns to 1 (WAIT_DONE->IDLE, IDLE->LAUNCH).

Boundaries:
- Pointer wrap: 17th push after 16 pops lands in entry 0.
- Full and pop in the same edge: a push in that edge is still rejected, because acceptance uses the registered full flag.
- Empty: FSM holds IDLE and o_tx_data retains the last byte.
- Reset mid-transfer: all state clears immediately; the byte in flight and queued bytes are discarded; o_tx_start=0.

Optional Feature:
Macro UART_TX_FIFO_OVF_EN.
- Defined: o_overflow is a sticky flag, set on the edge where i_wr_en=1 and o_full=0 is false (push attempted while full).
- o_overflow clears on i_clr_ovf=1. If set and clear occur in the same edge, set wins.
- Reset value of o_overflow is 0.
- Not defined: o_overflow and i_clr_ovf ports are absent and dropped writes are unflagged.

Test Plan:
1. Reset, then push 0xA5 with i_tx_done=1 -> o_tx_start high one cycle, 2 edges after the push; o_tx_data=0xA5; o_empty=1 afterwards.
2. Push 0x11,0x22,0x33 back-to-back; model done falling 2 cycles after each start and rising 160 cycles later -> exactly three start pulses in order 0x11,0x22,0x33; no pulse while i_tx_done=0.
3. Hold i_tx_done=0 and push 16 bytes -> o_full=1, o_count=16. 17th push (0xFF) dropped: count stays 16 and 0xFF is never transmitted. With UART_TX_FIFO_OVF_EN, o_overflow=1 until i_clr_ovf.
4. Wrap: 16 pushes, drain all, then push 0x5A -> 0x5A is stored at entry 0 and transmitted correctly; o_count 0->1->0.
5. Simultaneous push and launch-pop with count=3 -> o_count remains 3; data order preserved.
6. Assert rst low during WAIT_DONE with 5 bytes queued -> o_tx_start=0, o_count=0, o_empty=1, o_tx_data=0 immediately. No launches after release until a new push.
